scalar_wb_arbiter: RTL

Shares the single write port of the scalar register file between the scalar pipeline's writeback and the vector unit's scalar-result path (vmv.x.s, vsetvl rd, reductions to x-registers).
- Arbitrates the two valid/ready requesters and registers the winning beat onto the register-file write port.
- Keeps a 32-entry scoreboard of x-registers reserved by in-flight vector instructions, so decode can stall scalar reads of not-yet-written results.

---
 rtl/scalar_wb_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/scalar_wb_arbiter.sv
// Scalar register-file write-port arbiter with x-register scoreboard.
// SCALAR_WB_RR_EN selects round-robin arbitration (default: scalar priority).
module scalar_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [4:0]      s_rd,
    input  logic [XLEN-1:0] s_data,
    input  logic            v_valid,
    output logic            v_ready,
    input  logic [4:0]      v_rd,
    input  logic [XLEN-1:0] v_data,
    input  logic            claim_valid,
    input  logic [4:0]      claim_rd,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [NREG-1:0] busy_vec,
    output logic            write,
    output logic            is_s,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] data
);

    logic            s_acc;
    logic            v_acc;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

`ifdef SCALAR_WB_RR_EN
    logic prefer_v;

    always_comb begin
        s_ready = rst && s_valid && (!v_valid || !prefer_v);
        v_ready = rst && v_valid && (!s_valid || prefer_v);
    end

    // Only contended accepts move the pointer; rst high guarantees an accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prefer_v <= 1'b0;
        end else if (s_valid && v_valid) begin
            prefer_v <= !prefer_v;
        end
    end
`else
    always_comb begin
        s_ready = rst && s_valid;
        v_ready = rst && v_valid && !s_valid;
    end
`endif

    assign s_acc = s_valid && s_ready;
    assign v_acc = v_valid && v_ready;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (claim_valid && claim_rd != 5'd0) begin
            set_mask[claim_rd] = 1'b1;
        end
        if (v_acc && v_rd != 5'd0) begin
            clr_mask[v_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy    <= '0;
            write   <= 1'b0;
            rd_addr <= 5'd0;
            data    <= '0;
        end else begin
            // Set after clear so a same-cycle reclaim stays reserved.
            busy <= (busy & ~clr_mask) | set_mask;
            if (s_acc) begin
                write   <= s_rd != 5'd0;
                rd_addr <= s_rd;
                data    <= s_data;
            end else if (v_acc) begin
                write   <= v_rd != 5'd0;
                rd_addr <= v_rd;
                data    <= v_data;
            end else begin
                write <= 1'b0;
            end
        end
    end

    assign is_s     = write;
    assign busy_vec = busy;

    assign rs1_busy = (busy[rs1_addr] || (write && rd_addr == rs1_addr))
                      && rs1_addr != 5'd0;
    assign rs2_busy = (busy[rs2_addr] || (write && rd_addr == rs2_addr))
                      && rs2_addr != 5'd0;

endmodule
